// File: rtl/operand_sel_reg.sv
// operand_sel_reg
//   Operand-select stage: an N-input source multiplexer feeding a
//   load-enabled operand register (the A/B operand latches).
//   Non-memory loads complete on the request edge. Loads from the memory
//   source wait MEM_LAT cycles before capturing, while busy is high.
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous active-low reset
//   srcData     flattened sources, source i at [i*WIDTH +: WIDTH]
//   muxControl  source select, sampled together with loadReq
//   loadReq     request to load the selected source into regOut
//   muxOut      combinational mux of srcData (zero for out-of-range select)
//   regOut      operand register
//   busy        high while a memory-source load is waiting
//   loadDone    one-cycle pulse after regOut has been updated
//   reqDropped  one-cycle pulse when a loadReq was ignored (load pending)

module operand_sel_reg #(
  parameter int               WIDTH     = 32,
  parameter int               NUM_IN    = 4,
  parameter int               SEL_W     = 2,
  parameter int               MEM_SRC   = 0,
  parameter int               MEM_LAT   = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_IN*WIDTH-1:0] srcData,
  input  logic [SEL_W-1:0]        muxControl,
  input  logic                    loadReq,
  output logic [WIDTH-1:0]        muxOut,
  output logic [WIDTH-1:0]        regOut,
  output logic                    busy,
  output logic                    loadDone,
  output logic                    reqDropped
);

  // Every select code gets a slot; codes at or above NUM_IN read zero,
  // so the mux needs no separate range compare.
  localparam int NUM_SLOT = 1 << SEL_W;

  // Memory loads with zero latency behave exactly like ordinary loads.
  localparam bit HAS_WAIT = (MEM_LAT > 0);

  // Counter start value; only meaningful when a wait state exists.
  localparam logic [3:0] LAT_M1 = HAS_WAIT ? 4'(MEM_LAT - 1) : 4'd0;

  generate
    if (NUM_IN < 2 || NUM_IN > 16) begin : g_bad_num_in
      $error("operand_sel_reg: NUM_IN must be 2..16");
    end
    if (NUM_IN > NUM_SLOT) begin : g_bad_sel_w
      $error("operand_sel_reg: SEL_W too small for NUM_IN");
    end
    if (MEM_SRC < 0 || MEM_SRC >= NUM_IN) begin : g_bad_mem_src
      $error("operand_sel_reg: MEM_SRC out of range");
    end
    if (MEM_LAT < 0 || MEM_LAT > 15) begin : g_bad_mem_lat
      $error("operand_sel_reg: MEM_LAT must be 0..15");
    end
  endgenerate

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t                 state_reg;
  logic   [3:0]           cnt_reg;
  logic   [WIDTH-1:0]     src_arr [NUM_SLOT];
  logic   [WIDTH-1:0]     mem_data;
  logic                   sel_is_mem;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLOT; gi++) begin : g_src
      if (gi < NUM_IN) begin : g_used
        assign src_arr[gi] = srcData[gi*WIDTH +: WIDTH];
      end else begin : g_empty
        assign src_arr[gi] = '0;
      end
    end
  endgenerate

  assign muxOut     = src_arr[muxControl];
  assign mem_data   = srcData[MEM_SRC*WIDTH +: WIDTH];
  assign sel_is_mem = (muxControl == SEL_W'(MEM_SRC));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg  <= S_IDLE;
      cnt_reg    <= 4'd0;
      regOut     <= RESET_VAL;
      busy       <= 1'b0;
      loadDone   <= 1'b0;
      reqDropped <= 1'b0;
    end else begin
      // Both status outputs are single-cycle pulses unless re-set below.
      loadDone   <= 1'b0;
      reqDropped <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (loadReq) begin
            if (HAS_WAIT && sel_is_mem) begin
              state_reg <= S_WAIT;
              cnt_reg   <= LAT_M1;
              busy      <= 1'b1;
            end else begin
              regOut   <= muxOut;
              loadDone <= 1'b1;
            end
          end
        end
        S_WAIT: begin
          // No queueing: any request seen while waiting is dropped,
          // including one on the capture edge itself.
          reqDropped <= loadReq;
          if (cnt_reg == 4'd0) begin
            // Capture always from the memory source; muxControl may
            // have moved on since the request.
            regOut    <= mem_data;
            loadDone  <= 1'b1;
            busy      <= 1'b0;
            state_reg <= S_IDLE;
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

endmodule
